// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the access legality checks that do not depend on lane alignment.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic funct3_illegal(input logic write, input logic [2:0] funct3);
    if (write) return funct3 > F3_W;
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Any address bit above the word-index field selects a nonexistent location.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// RV32I lane alignment: extracts and extends load data from a raw word, and builds
// byte enables plus lane-replicated write data for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata_raw,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic        misalign
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = rdata_raw[{addr_lo, 3'b000} +: 8];
  assign half_val = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    load_data  = '0;
    byte_en    = '0;
    wdata_lane = '0;
    misalign   = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: begin
        load_data  = (funct3 == F3_B) ? {{24{byte_val[7]}}, byte_val} : {24'd0, byte_val};
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        misalign   = addr_lo[0];
        load_data  = (funct3 == F3_H) ? {{16{half_val[15]}}, half_val} : {16'd0, half_val};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_W: begin
        misalign   = addr_lo != 2'b00;
        load_data  = rdata_raw;
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one outstanding request, programmable wait
// states, byte-lane aligned loads/stores and a per-response error flag.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic        cap_write, cap_write_n;
  logic [2:0]  cap_funct3, cap_funct3_n;
  logic [31:0] cap_addr, cap_addr_n;
  logic [31:0] cap_wdata, cap_wdata_n;
  logic        req_ready_n, resp_valid_n, resp_error_n;
  logic [31:0] resp_rdata_n;

  logic [31:0] mem [DEPTH];

  logic                  acc_write;
  logic [2:0]            acc_funct3;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           load_data, wdata_lane;
  logic [3:0]            byte_en;
  logic                  misalign, acc_error, commit, mem_we;

  // With zero wait states the commit happens on the accept edge, before capture.
  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign word_idx   = acc_addr[ADDR_WIDTH+1:2];

  mem_lane_align u_align (
    .funct3     (acc_funct3),
    .addr_lo    (acc_addr[1:0]),
    .rdata_raw  (mem[word_idx]),
    .wdata      (acc_wdata),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .misalign   (misalign)
  );

  assign acc_error = misalign | funct3_illegal(acc_write, acc_funct3)
                   | addr_out_of_range(acc_addr, ADDR_WIDTH);
  assign mem_we    = commit & acc_write & ~acc_error & ~reset;

  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    cap_write_n  = cap_write;
    cap_funct3_n = cap_funct3;
    cap_addr_n   = cap_addr;
    cap_wdata_n  = cap_wdata;
    req_ready_n  = req_ready;
    resp_valid_n = resp_valid;
    resp_rdata_n = resp_rdata;
    resp_error_n = resp_error;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid && req_ready) begin
          req_ready_n  = 1'b0;
          cap_write_n  = req_write;
          cap_funct3_n = req_funct3;
          cap_addr_n   = req_addr;
          cap_wdata_n  = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
            commit  = 1'b1;
          end else begin
            state_n    = WAIT;
            wait_cnt_n = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_n = RESP;
          commit  = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          req_ready_n  = 1'b1;
          resp_valid_n = 1'b0;
          resp_rdata_n = '0;
          resp_error_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (commit) begin
      resp_valid_n = 1'b1;
      resp_error_n = acc_error;
      resp_rdata_n = (acc_error || acc_write) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cap_write  <= 1'b0;
      cap_funct3 <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_cnt_n;
      cap_write  <= cap_write_n;
      cap_funct3 <= cap_funct3_n;
      cap_addr   <= cap_addr_n;
      cap_wdata  <= cap_wdata_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_error <= resp_error_n;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents persist across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed vector table, backpressure and reset sequences,
// randomized traffic against a byte-addressed reference model, plus a zero-wait instance.
module tb_data_mem_responder;

  localparam int AW = 10;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;

  logic        z_req_valid = 1'b0, z_req_write = 1'b0;
  logic        z_resp_ready = 1'b1;
  logic [2:0]  z_req_funct3 = '0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic        z_req_ready, z_resp_valid, z_resp_error;
  logic [31:0] z_resp_rdata;

  int checks = 0;
  int errors = 0;

  bit [7:0] mem_b [int];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_funct3(z_req_funct3), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_error(z_resp_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, arithmetic sign extension.
  function automatic void model(input bit w, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] rd, output bit err);
    int size;
    bit sgn, legal;
    longint v;
    size = 1; sgn = 0; rd = '0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: size = 1;
    endcase
    legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (a % size != 0) || (longint'(a) >= (longint'(4) << AW));
    if (err) return;
    if (w) begin
      for (int i = 0; i < size; i++) mem_b[int'(a) + i] = 8'(wd >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mem_b[int'(a) + i]) << (8 * i));
      if (sgn && v[8*size-1]) v = v - (longint'(1) << (8 * size));
      rd = v[31:0];
    end
  endfunction

  // Starts and ends on a negedge; lat counts negedges from accept until resp_valid is seen.
  task automatic xact(input bit w, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                      output bit [31:0] rd, output bit er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!resp_valid) lat = -1;
    rd = resp_rdata; er = resp_error;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic run(input string name, input bit w, input bit [2:0] f3, input bit [31:0] a,
                     input bit [31:0] wd);
    bit [31:0] rd, exp_rd;
    bit er, exp_er;
    int lat;
    model(w, f3, a, wd, exp_rd, exp_er);
    xact(w, f3, a, wd, rd, er, lat);
    check({name, " rdata"}, rd, exp_rd);
    check({name, " error"}, 32'(er), 32'(exp_er));
    check({name, " latency"}, lat, WC + 1);
  endtask

  typedef struct {
    string     name;
    bit        w;
    bit [2:0]  f3;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] exp_rd;
    bit        exp_er;
  } vec_t;

  initial begin
    vec_t vecs[$];
    bit [31:0] rd, dummy;
    bit er, dummy_er;
    int lat, n;

    vecs.push_back('{"sw10",   1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{"lw10",   0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"sb13",   1, 3'd0, 32'h13,   32'h00000080, 32'h0,        0});
    vecs.push_back('{"lw10b",  0, 3'd2, 32'h10,   32'h0,        32'h80ADBEEF, 0});
    vecs.push_back('{"lb13",   0, 3'd0, 32'h13,   32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"lbu13",  0, 3'd4, 32'h13,   32'h0,        32'h00000080, 0});
    vecs.push_back('{"sh12",   1, 3'd1, 32'h12,   32'h00001234, 32'h0,        0});
    vecs.push_back('{"lh12",   0, 3'd1, 32'h12,   32'h0,        32'h00001234, 0});
    vecs.push_back('{"lh11",   0, 3'd1, 32'h11,   32'h0,        32'h0,        1});
    vecs.push_back('{"sw14",   1, 3'd2, 32'h14,   32'h55667788, 32'h0,        0});
    vecs.push_back('{"sw16",   1, 3'd2, 32'h16,   32'hFFFFFFFF, 32'h0,        1});
    vecs.push_back('{"lw14",   0, 3'd2, 32'h14,   32'h0,        32'h55667788, 0});
    vecs.push_back('{"lw1000", 0, 3'd2, 32'h1000, 32'h0,        32'h0,        1});
    vecs.push_back('{"ld011",  0, 3'd3, 32'h10,   32'h0,        32'h0,        1});
    vecs.push_back('{"st011",  1, 3'd3, 32'h10,   32'h0,        32'h0,        1});
    vecs.push_back('{"st100",  1, 3'd4, 32'h10,   32'h0,        32'h0,        1});
    vecs.push_back('{"lw10c",  0, 3'd2, 32'h10,   32'h0,        32'h1234BEEF, 0});
    vecs.push_back('{"sw20",   1, 3'd2, 32'h20,   32'h11111111, 32'h0,        0});
    vecs.push_back('{"lw20",   0, 3'd2, 32'h20,   32'h0,        32'h11111111, 0});

    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 0);
    check("rst resp_valid", 32'(resp_valid), 0);
    check("rst resp_rdata", resp_rdata, 0);
    check("rst resp_error", 32'(resp_error), 0);
    reset = 1'b0;
    @(negedge clk);
    check("req_ready after reset", 32'(req_ready), 1);

    // Zero-wait instance: response visible in the cycle right after the accept edge.
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_funct3 = 3'd2;
    z_req_addr = 32'h8; z_req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    z_req_valid = 1'b0;
    check("w0 sw resp_valid", 32'(z_resp_valid), 1);
    check("w0 sw error", 32'(z_resp_error), 0);
    @(negedge clk);
    check("w0 idle resp_valid", 32'(z_resp_valid), 0);
    z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 32'h8;
    @(negedge clk);
    z_req_valid = 1'b0;
    check("w0 lw resp_valid", 32'(z_resp_valid), 1);
    check("w0 lw rdata", z_resp_rdata, 32'hA5A5A5A5);

    foreach (vecs[i]) begin
      model(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, dummy, dummy_er);
      xact(vecs[i].w, vecs[i].f3, vecs[i].a, vecs[i].wd, rd, er, lat);
      check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, " error"}, 32'(er), 32'(vecs[i].exp_er));
      check({vecs[i].name, " latency"}, lat, WC + 1);
    end

    // Backpressure: response held, a competing store is presented and must be ignored.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    req_write = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", 32'(resp_valid), 1);
      check("bp rdata", resp_rdata, 32'h1234BEEF);
      check("bp error", 32'(resp_error), 0);
      check("bp req_ready", 32'(req_ready), 0);
      req_valid = ~req_valid;
      @(negedge clk);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp release resp_valid", 32'(resp_valid), 0);
    check("bp release req_ready", 32'(req_ready), 1);
    check("bp release rdata", resp_rdata, 0);
    run("post bp lw10", 0, 3'd2, 32'h10, 0);

    // Reset while a response is held: outputs clear between clock edges.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("pre-reset resp_valid", 32'(resp_valid), 1);
    #2 reset = 1'b1;
    #1;
    check("async rst resp_valid", 32'(resp_valid), 0);
    check("async rst rdata", resp_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset during WAIT of a store: the store must never land.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("wait rst resp_valid", 32'(resp_valid), 0);
    check("wait rst req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("held rst req_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post rst req_ready", 32'(req_ready), 1);
    run("post rst lw20", 0, 3'd2, 32'h20, 0);

    // Randomized traffic over a prefilled window, with occasional out-of-range addresses.
    for (int i = 0; i < 16; i++) run("prefill", 1, 3'd2, 32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      bit [31:0] a;
      a = 32'h100 + ($urandom % 64);
      if ($urandom % 8 == 0) a = a | (32'h1 << (12 + $urandom % 20));
      run("random", 1'($urandom), 3'($urandom), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
